// File: rtl/led_pkg.sv
// Shared types and constants for the LED array controller.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_PWM   = 2'b11
    } led_mode_t;

    // Width of the per-tick counter increment.
    localparam int STEP_W = 3;

    // Only blink and PWM channels run their rate counter.
    function automatic logic is_counting(input led_mode_t m);
        return (m == LED_BLINK) || (m == LED_PWM);
    endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: config registers, rate counter with wrap pulse,
// and the registered LED drive for the selected mode.
module led_chan
    import led_pkg::*;
#(
    parameter int CNT_W      = 27,
    parameter int DUTY_W     = 8,
    parameter int DEF_PERIOD = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              we,
    input  led_mode_t         cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              led,
    output logic              wrap
);

    localparam int PW = CNT_W + DUTY_W;

    led_mode_t         mode_q;
    logic [CNT_W-1:0]  period_q;
    logic [STEP_W-1:0] step_q;
    logic [DUTY_W-1:0] duty_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              blink_q;

    logic [CNT_W-1:0]  peff;
    logic [CNT_W:0]    sum;
    logic              hit;
    logic              counting;
    logic              pwm_on;
    logic              led_d;

    // Counter arithmetic and mode decode; sum is one bit wider so it cannot overflow.
    always_comb begin
        peff     = (period_q == '0) ? CNT_W'(1) : period_q;
        sum      = {1'b0, cnt_q} + (CNT_W+1)'(step_q);
        hit      = (sum >= {1'b0, peff});
        counting = is_counting(mode_q);
        // Compare cnt/peff against duty/2^DUTY_W without a divider.
        pwm_on   = ({cnt_q, {DUTY_W{1'b0}}} < (PW'(duty_q) * PW'(peff)));
        led_d    = 1'b0;
        case (mode_q)
            LED_ON:    led_d = 1'b1;
            LED_BLINK: led_d = blink_q;
            LED_PWM:   led_d = pwm_on;
            default:   led_d = 1'b0;
        endcase
    end

    // Config registers, loaded in one shot by the channel write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= LED_OFF;
            period_q <= CNT_W'(DEF_PERIOD);
            step_q   <= STEP_W'(1);
            duty_q   <= '0;
        end else if (we) begin
            mode_q   <= cfg_mode;
            period_q <= cfg_period;
            step_q   <= cfg_step;
            duty_q   <= cfg_duty;
        end
    end

    // Rate counter, wrap pulse and blink state; a write overrides any tick this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (we) begin
                cnt_q   <= '0;
                blink_q <= 1'b0;
            end else if (!counting) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (hit) begin
                    cnt_q <= '0;
                    wrap  <= 1'b1;
                    if (mode_q == LED_BLINK) blink_q <= ~blink_q;
                end else begin
                    cnt_q <= sum[CNT_W-1:0];
                end
            end
        end
    end

    // Registered LED drive, follows the channel state one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= 1'b0;
        else        led <= led_d;
    end

endmodule

// File: rtl/led_array_ctrl.sv
// Multi-channel LED driver: shared tick prescaler, config write decode,
// and one led_chan per channel.
module led_array_ctrl
    import led_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 27,
    parameter int DUTY_W     = 8,
    parameter int PRESCALE   = 1,
    parameter int DEF_PERIOD = 50_000_000
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  led_mode_t                                   cfg_mode,
    input  logic [CNT_W-1:0]                            cfg_period,
    input  logic [STEP_W-1:0]                           cfg_step,
    input  logic [DUTY_W-1:0]                           cfg_duty,
    output logic [NUM_CH-1:0]                           led,
    output logic [NUM_CH-1:0]                           wrap
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   ps_q;
    logic              tick;
    logic [NUM_CH-1:0] ch_we;

    // With PRESCALE=1 ps_q stays 0 and tick is high every cycle.
    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    // Shared prescaler counting 0..PRESCALE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ps_q <= '0;
        else if (tick) ps_q <= '0;
        else           ps_q <= ps_q + PS_W'(1);
    end

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        led_chan #(
            .CNT_W      (CNT_W),
            .DUTY_W     (DUTY_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .we         (ch_we[i]),
            .cfg_mode   (cfg_mode),
            .cfg_period (cfg_period),
            .cfg_step   (cfg_step),
            .cfg_duty   (cfg_duty),
            .led        (led[i]),
            .wrap       (wrap[i])
        );
    end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Directed bench for led_array_ctrl: a PRESCALE=1 three-channel instance
// and a PRESCALE=5 four-channel instance sharing the config bus.
module tb_led_array_ctrl;
    import led_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic        cfg_we5;
    logic [1:0]  cfg_ch;
    led_mode_t   cfg_mode;
    logic [26:0] cfg_period;
    logic [2:0]  cfg_step;
    logic [7:0]  cfg_duty;
    logic [2:0]  led;
    logic [2:0]  wrap;
    logic [3:0]  led5;
    logic [3:0]  wrap5;

    int checks = 0;
    int errors = 0;

    led_array_ctrl #(
        .NUM_CH(3), .CNT_W(27), .DUTY_W(8), .PRESCALE(1), .DEF_PERIOD(50_000_000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_step(cfg_step),
        .cfg_duty(cfg_duty), .led(led), .wrap(wrap)
    );

    led_array_ctrl #(
        .NUM_CH(4), .CNT_W(27), .DUTY_W(8), .PRESCALE(5), .DEF_PERIOD(50_000_000)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we5), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_step(cfg_step),
        .cfg_duty(cfg_duty), .led(led5), .wrap(wrap5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge,
    // and the task returns at the negedge after it.
    task automatic wr(input logic five, input logic [1:0] ch, input led_mode_t m,
                      input logic [26:0] p, input logic [2:0] s, input logic [7:0] d);
        cfg_ch = ch; cfg_mode = m; cfg_period = p; cfg_step = s; cfg_duty = d;
        if (five) cfg_we5 = 1'b1;
        else      cfg_we  = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_we5 = 1'b0;
    endtask

    initial begin
        int  n;
        logic found;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_we5 = 1'b0; cfg_ch = '0;
        cfg_mode = LED_OFF; cfg_period = '0; cfg_step = '0; cfg_duty = '0;

        // Reset state
        #1;
        chk("rst_outputs", {led, wrap, led5, wrap5}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("idle_after_rst", {led, wrap, led5, wrap5}, 0);
        end

        // cfg_ch == NUM_CH must not touch any channel
        wr(1'b0, 2'd3, LED_ON, 27'd4, 3'd1, 8'd255);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("bad_ch_ignored", {led, wrap}, 0);
        end

        // ch0 blink, period 4, step 1
        wr(1'b0, 2'd0, LED_BLINK, 27'd4, 3'd1, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("b0_wrap", wrap[0], (k % 4 == 0));
            chk("b0_led", led[0], ((k - 1) / 4) % 2);
            chk("b0_others", {led[2:1], wrap[2:1]}, 0);
        end

        // Write lands on the edge where ch0 would wrap
        repeat (3) @(negedge clk);
        wr(1'b0, 2'd0, LED_BLINK, 27'd4, 3'd1, 8'd0);
        chk("coll_no_wrap", wrap[0], 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("coll_wrap", wrap[0], (k == 4));
            chk("coll_led", led[0], (k == 5));
        end

        // Write mid-count with blink state high: cnt and blink cleared
        wr(1'b0, 2'd0, LED_BLINK, 27'd4, 3'd1, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("mid_wrap", wrap[0], (k == 4));
            chk("mid_led", led[0], 0);
        end
        wr(1'b0, 2'd0, LED_OFF, 27'd4, 3'd1, 8'd0);

        // ch1 blink, period 10, step 3: wrap every 4 ticks
        wr(1'b0, 2'd1, LED_BLINK, 27'd10, 3'd3, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("b1_wrap", wrap[1], (k % 4 == 0));
            chk("b1_led", led[1], ((k - 1) / 4) % 2);
        end
        // step 0 freezes the counter
        wr(1'b0, 2'd1, LED_BLINK, 27'd10, 3'd0, 8'd0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("step0_frozen", {led[1], wrap[1]}, 0);
        end

        // ch2 PWM, period 8, duty 128: 50%
        wr(1'b0, 2'd2, LED_PWM, 27'd8, 3'd1, 8'd128);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("pwm50_led", led[2], (((k - 1) % 8) < 4));
            chk("pwm50_wrap", wrap[2], (k % 8 == 0));
        end
        wr(1'b0, 2'd2, LED_PWM, 27'd8, 3'd1, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("pwm0_led", led[2], 0);
        end
        wr(1'b0, 2'd2, LED_PWM, 27'd8, 3'd1, 8'd255);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("pwm255_led", led[2], 1);
            chk("pwm255_wrap", wrap[2], (k == 8));
        end
        // period 0 acts as 1: wrap every tick, cnt stays 0
        wr(1'b0, 2'd2, LED_PWM, 27'd0, 3'd1, 8'd128);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("p0_led", led[2], 1);
            chk("p0_wrap", wrap[2], 1);
        end

        // PRESCALE=5, ch3 blink period 2: wrap and toggle every 10 cycles
        wr(1'b1, 2'd3, LED_BLINK, 27'd2, 3'd1, 8'd0);
        n = 0; found = 1'b0;
        while (!found && n < 10) begin
            @(negedge clk);
            n++;
            if (wrap5[3]) found = 1'b1;
        end
        chk("ps5_first_wrap", found, 1);
        chk("ps5_led_at_wrap", led5[3], 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("ps5_wrap", wrap5[3], (k == 10 || k == 20));
            chk("ps5_led", led5[3], (k <= 10));
            chk("ps5_others", {led5[2:0], wrap5[2:0]}, 0);
        end

        // Asynchronous reset mid-operation
        @(negedge clk);
        chk("pre_rst_led2", led[2], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {led, wrap, led5, wrap5}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("idle_after_rst2", {led, wrap, led5, wrap5}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
